// File: rtl/arb_rr_responder.sv
// arb_rr_responder
//   Responder end of the REQ/GNT/REL arbitration interface. Grants a shared
//   resource to one of C_NUM_REQ requesters at a time in round-robin order.
//   An owner that holds the resource for C_MAX_HOLD cycles while another
//   requester waits is asked to let go via REL. An owner that keeps REQ high
//   for C_REL_TIMEOUT cycles of REL loses the grant, and revoke_pulse fires
//   for one cycle.
//
// Parameters
//   C_NUM_REQ     : number of requesters (2..16)
//   C_MAX_HOLD    : grant cycles before REL while others wait (0 = never)
//   C_REL_TIMEOUT : REL cycles before the grant is forcibly revoked (>= 1)
//
// Ports
//   aclk         in   clock, rising edge
//   areset       in   asynchronous active-high reset
//   s_req        in   per-requester REQ, level-sensitive
//   s_gnt        out  per-requester GNT, registered, one-hot or zero
//   s_rel        out  per-requester REL, registered, only the owner's bit
//   owner        out  index of the current owner (valid with owner_valid)
//   owner_valid  out  high whenever any s_gnt bit is high
//   revoke_pulse out  one-cycle pulse on a forced revoke
module arb_rr_responder #(
  parameter int C_NUM_REQ     = 4,
  parameter int C_MAX_HOLD    = 64,
  parameter int C_REL_TIMEOUT = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [C_NUM_REQ-1:0]         s_req,
  output logic [C_NUM_REQ-1:0]         s_gnt,
  output logic [C_NUM_REQ-1:0]         s_rel,
  output logic [$clog2(C_NUM_REQ)-1:0] owner,
  output logic                         owner_valid,
  output logic                         revoke_pulse
);

  localparam int IW = $clog2(C_NUM_REQ);
  // Counter widths only need to hold 0..limit-1.
  localparam int HW = (C_MAX_HOLD > 2) ? $clog2(C_MAX_HOLD) : 1;
  localparam int RW = (C_REL_TIMEOUT > 2) ? $clog2(C_REL_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(C_MAX_HOLD - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(C_REL_TIMEOUT - 1);
  localparam bit PREEMPT = (C_MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [C_NUM_REQ-1:0] idx_to_onehot(input logic [IW-1:0] idx);
    logic [C_NUM_REQ-1:0] oh;
    oh      = {C_NUM_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t               state_r, state_n_s;
  logic [C_NUM_REQ-1:0] gnt_r, gnt_n_s;
  logic [C_NUM_REQ-1:0] rel_r, rel_n_s;
  logic [IW-1:0]        owner_r, owner_n_s;
  logic [IW-1:0]        last_r, last_n_s;
  logic [HW-1:0]        hold_r, hold_n_s;
  logic [RW-1:0]        relcnt_r, relcnt_n_s;
  logic                 owner_valid_r;
  logic                 revoke_r, revoke_n_s;

  logic                 pick_valid_s;
  logic [IW-1:0]        pick_idx_s;
  logic [IW-1:0]        scan_idx_s;
  logic                 owner_req_s;
  logic                 others_s;

  assign s_gnt        = gnt_r;
  assign s_rel        = rel_r;
  assign owner        = owner_r;
  assign owner_valid  = owner_valid_r;
  assign revoke_pulse = revoke_r;

  // While a grant is held, gnt_r is the owner's one-hot mask, so it splits
  // the request vector into "owner still wants it" and "someone else waits".
  assign owner_req_s = |(s_req & gnt_r);
  assign others_s    = |(s_req & ~gnt_r);

  // Round-robin pick: first requester after last_r, wrapping around.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = last_r;
    scan_idx_s   = last_r;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      scan_idx_s = IW'((int'(last_r) + k) % C_NUM_REQ);
      if (!pick_valid_s && s_req[scan_idx_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = scan_idx_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_n_s  = state_r;
    gnt_n_s    = gnt_r;
    rel_n_s    = rel_r;
    owner_n_s  = owner_r;
    last_n_s   = last_r;
    hold_n_s   = hold_r;
    relcnt_n_s = relcnt_r;
    revoke_n_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        rel_n_s = {C_NUM_REQ{1'b0}};
        if (pick_valid_s) begin
          gnt_n_s   = idx_to_onehot(pick_idx_s);
          owner_n_s = pick_idx_s;
          last_n_s  = pick_idx_s;
          hold_n_s  = {HW{1'b0}};
          state_n_s = ST_GRANT;
        end else begin
          gnt_n_s = {C_NUM_REQ{1'b0}};
        end
      end

      ST_GRANT: begin
        if (!owner_req_s) begin
          gnt_n_s   = {C_NUM_REQ{1'b0}};
          state_n_s = ST_IDLE;
        end else begin
          if (hold_r != HOLD_MAX) begin
            hold_n_s = hold_r + HW'(1'b1);
          end else begin
            hold_n_s = hold_r;
          end
          // Compare the pre-increment count so REL rises exactly
          // C_MAX_HOLD cycles after GNT when a competitor is already waiting.
          if (PREEMPT && (hold_r == HOLD_MAX) && others_s) begin
            rel_n_s    = gnt_r;
            relcnt_n_s = {RW{1'b0}};
            state_n_s  = ST_RELEASE;
          end else begin
            state_n_s = ST_GRANT;
          end
        end
      end

      ST_RELEASE: begin
        // A voluntary drop wins over a timeout expiring on the same edge.
        if (!owner_req_s) begin
          gnt_n_s   = {C_NUM_REQ{1'b0}};
          rel_n_s   = {C_NUM_REQ{1'b0}};
          state_n_s = ST_IDLE;
        end else if (relcnt_r == REL_LAST) begin
          gnt_n_s    = {C_NUM_REQ{1'b0}};
          rel_n_s    = {C_NUM_REQ{1'b0}};
          revoke_n_s = 1'b1;
          state_n_s  = ST_IDLE;
        end else begin
          relcnt_n_s = relcnt_r + RW'(1'b1);
        end
      end

      default: begin
        gnt_n_s   = {C_NUM_REQ{1'b0}};
        rel_n_s   = {C_NUM_REQ{1'b0}};
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered-output update.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r       <= ST_IDLE;
      gnt_r         <= {C_NUM_REQ{1'b0}};
      rel_r         <= {C_NUM_REQ{1'b0}};
      owner_r       <= {IW{1'b0}};
      last_r        <= IW'(C_NUM_REQ - 1);
      hold_r        <= {HW{1'b0}};
      relcnt_r      <= {RW{1'b0}};
      owner_valid_r <= 1'b0;
      revoke_r      <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      gnt_r         <= gnt_n_s;
      rel_r         <= rel_n_s;
      owner_r       <= owner_n_s;
      last_r        <= last_n_s;
      hold_r        <= hold_n_s;
      relcnt_r      <= relcnt_n_s;
      owner_valid_r <= |gnt_n_s;
      revoke_r      <= revoke_n_s;
    end
  end

endmodule

// File: doc/arb_rr_responder.md
# arb_rr_responder

Responder end of the `arb_rtl` REQ/GNT/REL interface. It sits downstream of one or more arbitration wirethroughs, sees `C_NUM_REQ` requesters, and grants a shared resource to one of them at a time in round-robin order. When an owner holds the resource too long while others wait, it asserts REL to ask the owner to let go. If the owner ignores REL, it revokes the grant after a timeout.

## Interface
- `C_NUM_REQ`, default 4: number of requesters, legal range 2..16.
- `C_MAX_HOLD`, default 64: grant cycles before REL is asserted while another requester waits. 0 disables preemption; REL is then never asserted and the grant is never revoked.
- `C_REL_TIMEOUT`, default 16: cycles REL may stay high before the grant is forcibly revoked. Legal range ≥1.
- `aclk`, in, 1: the single clock; all logic is on its rising edge.
- `areset`, in, 1: reset, asynchronous and active-high.
- `s_req`, in, `C_NUM_REQ`: per-requester REQ, level-sensitive.
- `s_gnt`, out, `C_NUM_REQ`: per-requester GNT, registered, one-hot or zero.
- `s_rel`, out, `C_NUM_REQ`: per-requester REL, registered. Only the current owner's bit can be high.
- `owner`, out, `clog2(C_NUM_REQ)`: index of the current owner. Valid only while `owner_valid` is high.
- `owner_valid`, out, 1: high whenever any `s_gnt` bit is high.
- `revoke_pulse`, out, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- The FSM has three states: IDLE, GRANT, RELEASE.
- Reset values: state IDLE; `s_gnt`, `s_rel`, `owner_valid` and `revoke_pulse` all 0; `owner`, hold counter and REL counter all 0; round-robin pointer `last` = `C_NUM_REQ-1`, so requester 0 has first priority.
- IDLE:
  - If any `s_req` bit is high, select the first set bit scanning from `last+1` upward with wrap.
  - Set its `s_gnt` bit, load `owner` and `last` with that index, clear the hold counter, and go to GRANT.
- GRANT:
  - If `s_req[owner]` is 0: clear `s_gnt` and go to IDLE.
  - Otherwise the hold counter increments, saturating at `C_MAX_HOLD-1`.
  - If `C_MAX_HOLD != 0`, the counter equals `C_MAX_HOLD-1`, and any other `s_req` bit is high: set `s_rel[owner]`, clear the REL counter, and go to RELEASE.
  - If no other requester waits, stay in GRANT with the counter saturated. REL asserts on the first cycle another request appears.
- RELEASE:
  - `s_gnt[owner]` and `s_rel[owner]` are both high.
  - If `s_req[owner]` is 0: clear both and go to IDLE. This is a normal release, with no pulse.
  - Otherwise, if the REL counter equals `C_REL_TIMEOUT-1`: clear both, pulse `revoke_pulse`, and go to IDLE.
  - Otherwise the REL counter increments.
  - REL stays high even if the other requesters drop their REQ while in RELEASE.
- Because `last` equals the revoked or released owner, the next arbitration starts after it. A still-requesting former owner is re-granted only if no one else requests.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronous), with no `revoke_pulse`.

## Timing
- REQ sampled at edge N gives GNT visible after edge N. In other words, GNT rises in the cycle following the first cycle REQ was high.
- Owner REQ dropping, sampled at edge E, clears GNT and REL after E. Re-arbitration happens at E+1.
  - There is therefore always at least one cycle with all GNT low between two owners.
- REL rises after the edge where the hold count reaches `C_MAX_HOLD-1` with a competitor pending. With a competitor waiting from the start, REL rises `C_MAX_HOLD` cycles after GNT rose.
- Forced revoke: GNT, REL and `revoke_pulse` change at the edge ending the `C_REL_TIMEOUT`-th cycle of REL high. The pulse lasts exactly one cycle.
- `owner` and `owner_valid` update in the same cycle as `s_gnt`.

## Test plan
- **Reset, then one requester:** release reset, `s_req`=0001 for 5 cycles, then 0000 → `s_gnt`=0001 from cycle 1 to 5, then 0000 one cycle after REQ drops; `s_rel` stays 0.
- **Round robin:** `s_req`=1111 with each owner dropping REQ 3 cycles after its grant and re-raising it one cycle later → grant order 0,1,2,3,0, with exactly one all-zero GNT cycle between grants.
- **Preemption with compliance:** `C_MAX_HOLD`=8. Requester 2 holds REQ, requester 0 requests from cycle 0 → `s_rel`=0100 after 8 grant cycles. Requester 2 drops REQ 3 cycles later → GNT goes to 0 one cycle after the drop; `revoke_pulse` stays 0.
- **Forced revoke:** `C_MAX_HOLD`=8, `C_REL_TIMEOUT`=4, and the owner ignores REL → GNT and REL clear after exactly 4 REL cycles, `revoke_pulse` is high for 1 cycle, and the waiting requester is granted on the next cycle.
- **No competitor:** `C_MAX_HOLD`=8, a single requester holds for 100 cycles → REL never asserts. A second REQ appearing at cycle 50 → REL asserts on the next cycle.
- **Asynchronous reset mid-RELEASE:** pulse `areset` between clock edges while in RELEASE → `s_gnt`, `s_rel` and `owner_valid` go to 0 immediately with no `revoke_pulse`, and the first grant after reset goes to requester 0.
